// File: rtl/plab2_mem_pkg.sv
// rtl/plab2_mem_pkg.sv - shared message layout, type codes and byte-mask helper
// Purpose: field offsets and widths for VC_MEM_REQ(8,32,32) / VC_MEM_RESP(8,32),
//          memory request type codes, and the byte-lane mask function.
// Ports: none (package).
package plab2_mem_pkg;

  localparam int REQ_NBITS  = 77;
  localparam int RESP_NBITS = 45;

  // Request fields
  localparam int REQ_TYPE_LSB   = 74;
  localparam int REQ_OPAQUE_LSB = 66;
  localparam int REQ_ADDR_LSB   = 34;
  localparam int REQ_LEN_LSB    = 32;
  localparam int REQ_DATA_LSB   = 0;

  // Response fields
  localparam int RESP_TYPE_LSB   = 42;
  localparam int RESP_OPAQUE_LSB = 34;
  localparam int RESP_LEN_LSB    = 32;
  localparam int RESP_DATA_LSB   = 0;

  localparam int TYPE_W   = 3;
  localparam int OPAQUE_W = 8;
  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 2;
  localparam int DATA_W   = 32;

  // Response entry carried through pipe and FIFO: {dom, resp_msg}
  localparam int ENTRY_W = RESP_NBITS + 1;

  localparam logic [TYPE_W-1:0] MEM_READ  = 3'd0;
  localparam logic [TYPE_W-1:0] MEM_WRITE = 3'd1;
  localparam logic [TYPE_W-1:0] MEM_INIT  = 3'd2;

  // Byte lanes touched by an access; len 0 means a full word. Lanes that
  // would fall past byte 3 are dropped, truncating the access at word end.
  function automatic logic [3:0] byte_mask(input logic [1:0] offset,
                                           input logic [1:0] len);
    logic [3:0] base;
    logic [7:0] shifted;
    case (len)
      2'd1:    base = 4'b0001;
      2'd2:    base = 4'b0011;
      2'd3:    base = 4'b0111;
      default: base = 4'b1111;
    endcase
    shifted = {4'b0000, base} << offset;
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/plab2_mem_resp_fifo.sv
// rtl/plab2_mem_resp_fifo.sv - response FIFO with registered head and same-cycle enq/deq
// Purpose: holds responses awaiting memresp_rdy in arrival order.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   enq_val, enq_data   push side (accepted when not full, or when full and deq fires)
//   deq_val, deq_rdy    pop handshake
//   deq_data            head entry, driven straight from storage flops
module plab2_mem_resp_fifo #(
  parameter int p_depth = 4,
  parameter int p_width = 46
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  input  logic [p_width-1:0] enq_data,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_width-1:0] deq_data
);

  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);

  logic [p_width-1:0] store [p_depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               deq_fire;
  logic               enq_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign deq_val  = (count != '0);
  assign deq_data = store[rd_ptr];
  assign deq_fire = deq_val && deq_rdy;
  // When full, the departing head frees the slot the new entry lands in.
  assign enq_fire = enq_val && ((count != CW'(p_depth)) || deq_fire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < p_depth; i++) begin
        store[i] <= '0;
      end
    end else begin
      if (enq_fire) begin
        store[wr_ptr] <= enq_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (deq_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/plab2_mem_domain_responder.sv
// rtl/plab2_mem_domain_responder.sv - fixed-latency memory responder with security-domain tagging
// Purpose: services VC_MEM_REQ(8,32,32) messages against a word array and returns
//          VC_MEM_RESP(8,32) messages in request order after p_latency cycles,
//          forwarding the requester domain with each response.
// Optional feature macro: PLAB2_MEM_DOMAIN_CHECK_EN (per-word domain tags and L/H access checks).
// Ports:
//   clk, reset                          clock, asynchronous active-low reset
//   sec_domain                          requester domain, sampled at request fire
//   memreq_msg, memreq_val, memreq_rdy  request channel
//   memresp_msg, memresp_val, memresp_rdy response channel
//   memresp_dom                         domain of the head response
module plab2_mem_domain_responder
  import plab2_mem_pkg::*;
#(
  parameter int p_mem_nwords   = 256,
  parameter int p_latency      = 1,
  parameter int p_max_inflight = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_domain,
  input  logic [REQ_NBITS-1:0]  memreq_msg,
  input  logic                  memreq_val,
  output logic                  memreq_rdy,
  output logic [RESP_NBITS-1:0] memresp_msg,
  output logic                  memresp_val,
  input  logic                  memresp_rdy,
  output logic                  memresp_dom
);

  localparam int AW = $clog2(p_mem_nwords);
  localparam int CW = $clog2(p_max_inflight + 1);

  // Request decode
  logic [TYPE_W-1:0]   req_type;
  logic [OPAQUE_W-1:0] req_opaque;
  logic [ADDR_W-1:0]   req_addr;
  logic [LEN_W-1:0]    req_len;
  logic [DATA_W-1:0]   req_data;

  assign req_type   = memreq_msg[REQ_TYPE_LSB   +: TYPE_W];
  assign req_opaque = memreq_msg[REQ_OPAQUE_LSB +: OPAQUE_W];
  assign req_addr   = memreq_msg[REQ_ADDR_LSB   +: ADDR_W];
  assign req_len    = memreq_msg[REQ_LEN_LSB    +: LEN_W];
  assign req_data   = memreq_msg[REQ_DATA_LSB   +: DATA_W];

  // Address bits above the array size wrap onto the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_W-1:AW+2];

  logic req_fire;
  logic resp_fire;
  assign req_fire  = memreq_val && memreq_rdy;
  assign resp_fire = memresp_val && memresp_rdy;

  // Array access
  logic [DATA_W-1:0] mem [p_mem_nwords];
  logic [AW-1:0]     widx;
  logic [3:0]        bmask;
  logic [DATA_W-1:0] lane_mask;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] resp_data;
  logic              is_read;
  logic              is_write;
  logic              tag_block;
  logic              wr_en;

  assign widx      = req_addr[AW+1:2];
  assign bmask     = byte_mask(req_addr[1:0], req_len);
  assign lane_mask = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
  assign shamt     = {req_addr[1:0], 3'b000};
  assign rd_word   = mem[widx];
  assign rd_data   = (rd_word & lane_mask) >> shamt;
  assign wr_word   = (rd_word & ~lane_mask) | ((req_data << shamt) & lane_mask);
  assign is_read   = (req_type == MEM_READ);
  assign is_write  = (req_type == MEM_WRITE) || (req_type == MEM_INIT);

`ifdef PLAB2_MEM_DOMAIN_CHECK_EN
  // One tag per word recording the domain of its last accepted writer.
  logic tags [p_mem_nwords];

  // An L requester may neither see nor overwrite an H-tagged word.
  assign tag_block = !sec_domain && tags[widx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < p_mem_nwords; i++) begin
        tags[i] <= 1'b0;
      end
    end else if (wr_en) begin
      tags[widx] <= sec_domain;
    end
  end
`else
  assign tag_block = 1'b0;
`endif

  assign wr_en     = req_fire && is_write && !tag_block;
  assign resp_data = (is_read && !tag_block) ? rd_data : '0;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[widx] <= wr_word;
    end
  end

  // Latency pipe. The FIFO's registered head provides the last cycle of
  // latency, so the pipe itself holds p_latency-1 stages.
  logic [ENTRY_W-1:0] entry;
  logic               pipe_val;
  logic [ENTRY_W-1:0] pipe_data;

  assign entry = {sec_domain, req_type, req_opaque, req_len, resp_data};

  if (p_latency <= 1) begin : g_no_pipe
    assign pipe_val  = req_fire;
    assign pipe_data = entry;
  end else begin : g_pipe
    logic [p_latency-2:0] val_q;
    logic [ENTRY_W-1:0]   data_q [p_latency-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        val_q <= '0;
        for (int i = 0; i < p_latency - 1; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        val_q[0]  <= req_fire;
        data_q[0] <= entry;
        for (int i = 1; i < p_latency - 1; i++) begin
          val_q[i]  <= val_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign pipe_val  = val_q[p_latency-2];
    assign pipe_data = data_q[p_latency-2];
  end

  // Output FIFO
  logic [ENTRY_W-1:0] head;

  plab2_mem_resp_fifo #(
    .p_depth (p_max_inflight),
    .p_width (ENTRY_W)
  ) u_resp_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (pipe_val),
    .enq_data (pipe_data),
    .deq_val  (memresp_val),
    .deq_rdy  (memresp_rdy),
    .deq_data (head)
  );

  assign memresp_msg = head[RESP_NBITS-1:0];
  assign memresp_dom = head[RESP_NBITS];

  // Inflight accounting covers pipe plus FIFO, so the FIFO can never overflow.
  // memreq_rdy is registered from the next count, keeping it off memreq_val.
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_nxt;

  assign inflight_nxt = inflight + CW'(req_fire) - CW'(resp_fire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight   <= '0;
      memreq_rdy <= 1'b0;
    end else begin
      inflight   <= inflight_nxt;
      memreq_rdy <= (inflight_nxt < CW'(p_max_inflight));
    end
  end

endmodule

// File: tb/tb_plab2_mem_domain_responder.sv
// tb/tb_plab2_mem_domain_responder.sv - directed and table-driven bench for plab2_mem_domain_responder
module tb_plab2_mem_domain_responder;

  logic        clk;
  logic        reset;
  logic        sec_domain;
  logic [76:0] memreq_msg;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [44:0] memresp_msg;
  logic        memresp_val;
  logic        memresp_rdy;
  logic        memresp_dom;

  plab2_mem_domain_responder dut (
    .clk         (clk),
    .reset       (reset),
    .sec_domain  (sec_domain),
    .memreq_msg  (memreq_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memresp_msg (memresp_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_dom (memresp_dom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [7:0]  opq;
    logic        dom;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [2:0] typ, input logic [31:0] addr,
                              input logic [1:0] len, input logic [31:0] data,
                              input logic [7:0] opq, input logic dom,
                              input logic [31:0] exp_data);
    vec_t v;
    v.typ = typ; v.addr = addr; v.len = len; v.data = data;
    v.opq = opq; v.dom = dom; v.exp_data = exp_data;
    vecs.push_back(v);
  endfunction

  // Called at #1 after a posedge; returns at #1 after the firing edge.
  task automatic do_req(input vec_t v);
    int n;
    memreq_msg = {v.typ, v.opq, v.addr, v.len, v.data};
    sec_domain = v.dom;
    memreq_val = 1'b1;
    n = 0;
    while (!memreq_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!memreq_rdy) chk("req rdy timeout", 64'(memreq_rdy), 64'd1);
    @(posedge clk); #1;
    memreq_val = 1'b0;
  endtask

  task automatic check_resp(input string nm, input vec_t v);
    chk({nm, " val"}, 64'(memresp_val), 64'd1);
    chk({nm, " msg"}, 64'(memresp_msg), 64'({v.typ, v.opq, v.len, v.exp_data}));
    chk({nm, " dom"}, 64'(memresp_dom), 64'(v.dom));
  endtask

  logic [45:0] model_q[$];
  logic [45:0] exp_e;
  vec_t        v;
  int          accepted;
  int          n;
  logic        saw_val;
  logic [7:0]  ropq;
  logic        rdom;
  int          k;

  initial begin
    reset       = 1'b1;
    sec_domain  = 1'b0;
    memreq_msg  = '0;
    memreq_val  = 1'b0;
    memresp_rdy = 1'b1;

    // ---------------- stimulus table ----------------
    add(3'd2, 32'h10,  2'd0, 32'hDEADBEEF, 8'h01, 1'b0, 32'h0);
    add(3'd0, 32'h10,  2'd0, 32'h0,        8'h5A, 1'b0, 32'hDEADBEEF);
    add(3'd2, 32'h20,  2'd0, 32'h11223344, 8'h02, 1'b0, 32'h0);
    add(3'd1, 32'h21,  2'd1, 32'h000000AB, 8'h03, 1'b0, 32'h0);
    add(3'd0, 32'h20,  2'd0, 32'h0,        8'h04, 1'b1, 32'h1122AB44);
    add(3'd0, 32'h23,  2'd1, 32'h0,        8'h05, 1'b0, 32'h00000011);
    add(3'd0, 32'h22,  2'd2, 32'h0,        8'h06, 1'b1, 32'h00001122);
    add(3'd0, 32'h21,  2'd3, 32'h0,        8'h07, 1'b0, 32'h001122AB);
    add(3'd0, 32'h23,  2'd2, 32'h0,        8'h08, 1'b0, 32'h00000011);
    add(3'd1, 32'h22,  2'd2, 32'h0000CAFE, 8'h09, 1'b0, 32'h0);
    add(3'd0, 32'h20,  2'd0, 32'h0,        8'h0A, 1'b1, 32'hCAFEAB44);
    add(3'd0, 32'h420, 2'd0, 32'h0,        8'h0B, 1'b0, 32'hCAFEAB44);
    add(3'd3, 32'h20,  2'd0, 32'hFFFFFFFF, 8'h0C, 1'b0, 32'h0);
    add(3'd0, 32'h20,  2'd0, 32'h0,        8'h0D, 1'b0, 32'hCAFEAB44);
    add(3'd0, 32'h12,  2'd2, 32'h0,        8'h0E, 1'b1, 32'h0000DEAD);
    add(3'd1, 32'h13,  2'd3, 32'h00112299, 8'h0F, 1'b0, 32'h0);
    add(3'd0, 32'h10,  2'd0, 32'h0,        8'h10, 1'b0, 32'h99ADBEEF);
    for (int i = 0; i < 6; i++)
      add(3'd2, 32'h50 + 32'(4 * i), 2'd0, 32'hA0000000 | 32'(i), 8'h20 + 8'(i), 1'b0, 32'h0);
    add(3'd2, 32'h40,  2'd0, 32'h00000055, 8'h30, 1'b1, 32'h0);
`ifdef PLAB2_MEM_DOMAIN_CHECK_EN
    add(3'd0, 32'h40,  2'd0, 32'h0,        8'h31, 1'b0, 32'h0);
`else
    add(3'd0, 32'h40,  2'd0, 32'h0,        8'h31, 1'b0, 32'h55);
`endif
    add(3'd1, 32'h40,  2'd0, 32'h00000077, 8'h32, 1'b0, 32'h0);
`ifdef PLAB2_MEM_DOMAIN_CHECK_EN
    add(3'd0, 32'h40,  2'd0, 32'h0,        8'h33, 1'b1, 32'h55);
`else
    add(3'd0, 32'h40,  2'd0, 32'h0,        8'h33, 1'b1, 32'h77);
`endif

    // ---------------- reset state ----------------
    #1 reset = 1'b0;
    #2;
    chk("reset rdy", 64'(memreq_rdy), 64'd0);
    chk("reset val", 64'(memresp_val), 64'd0);
    chk("reset msg", 64'(memresp_msg), 64'd0);
    chk("reset dom", 64'(memresp_dom), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("post reset rdy", 64'(memreq_rdy), 64'd1);

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i]);
      check_resp($sformatf("vec%0d", i), vecs[i]);
    end
    @(posedge clk); #1;
    chk("table drained", 64'(memresp_val), 64'd0);

    // ---------------- backpressure: 6 reads, 4 accepted ----------------
    memresp_rdy = 1'b0;
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      memreq_msg = {3'd0, 8'h80 + 8'(accepted), 32'h50 + 32'(4 * accepted), 2'd0, 32'd0};
      sec_domain = 1'b0;
      memreq_val = 1'b1;
      #1;
      if (memreq_rdy) accepted++;
      @(posedge clk); #1;
    end
    memreq_val = 1'b0;
    chk("bp accepted", 64'(accepted), 64'd4);
    chk("bp req rdy low", 64'(memreq_rdy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp hold%0d val", c), 64'(memresp_val), 64'd1);
      chk($sformatf("bp hold%0d msg", c), 64'(memresp_msg),
          64'({3'd0, 8'h80, 2'd0, 32'hA0000000}));
      @(posedge clk); #1;
    end
    memresp_rdy = 1'b1;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (!memresp_val && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("bp resp%0d msg", r), 64'(memresp_msg),
          64'({3'd0, 8'h80 + 8'(r), 2'd0, 32'hA0000000 | 32'(r)}));
      @(posedge clk); #1;
    end
    chk("bp drained val", 64'(memresp_val), 64'd0);
    chk("bp req rdy back", 64'(memreq_rdy), 64'd1);

    // ---------------- random traffic vs reference queue ----------------
    for (int c = 0; c < 100; c++) begin
      k    = $urandom_range(0, 5);
      ropq = 8'($urandom);
      rdom = 1'($urandom_range(0, 1));
      memreq_val  = ($urandom_range(0, 3) != 0);
      memresp_rdy = (c < 25) ? 1'b0 : 1'($urandom_range(0, 1));
      memreq_msg  = {3'd0, ropq, 32'h50 + 32'(4 * k), 2'd0, 32'd0};
      sec_domain  = rdom;
      #1;
      chk($sformatf("rnd%0d rdy", c), 64'(memreq_rdy), 64'(model_q.size() < 4));
      chk($sformatf("rnd%0d val", c), 64'(memresp_val), 64'(model_q.size() != 0));
      if (memresp_val && memresp_rdy && model_q.size() != 0) begin
        exp_e = model_q.pop_front();
        chk($sformatf("rnd%0d resp", c), 64'({memresp_dom, memresp_msg}), 64'(exp_e));
      end
      if (memreq_val && memreq_rdy)
        model_q.push_back({rdom, 3'd0, ropq, 2'd0, 32'hA0000000 | 32'(k)});
      @(posedge clk); #1;
    end
    memreq_val  = 1'b0;
    memresp_rdy = 1'b1;
    n = 0;
    while (model_q.size() != 0 && n < 20) begin
      if (memresp_val) begin
        exp_e = model_q.pop_front();
        chk("rnd drain resp", 64'({memresp_dom, memresp_msg}), 64'(exp_e));
      end
      @(posedge clk); #1;
      n++;
    end
    chk("rnd all delivered", 64'(model_q.size()), 64'd0);
    chk("rnd no extra", 64'(memresp_val), 64'd0);

    // ---------------- reset mid-traffic ----------------
    memresp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v.typ = 3'd0; v.addr = 32'h50 + 32'(4 * i); v.len = 2'd0; v.data = 32'd0;
      v.opq = 8'hC0 + 8'(i); v.dom = 1'b0; v.exp_data = 32'd0;
      do_req(v);
    end
    reset = 1'b0;
    #1;
    chk("mid reset val", 64'(memresp_val), 64'd0);
    chk("mid reset rdy", 64'(memreq_rdy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mid reset cyc%0d val", c), 64'(memresp_val), 64'd0);
    end
    memresp_rdy = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("release rdy", 64'(memreq_rdy), 64'd1);
    chk("release val", 64'(memresp_val), 64'd0);
    saw_val = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      saw_val = saw_val | memresp_val;
    end
    chk("no stale resp", 64'(saw_val), 64'd0);

    v.typ = 3'd0; v.addr = 32'h10; v.len = 2'd0; v.data = 32'd0;
    v.opq = 8'hD0; v.dom = 1'b0; v.exp_data = 32'h99ADBEEF;
    do_req(v);
    check_resp("post reset read", v);
    @(posedge clk); #1;
    v.addr = 32'h40; v.opq = 8'hD1;
`ifdef PLAB2_MEM_DOMAIN_CHECK_EN
    v.exp_data = 32'h55;
`else
    v.exp_data = 32'h77;
`endif
    do_req(v);
    check_resp("post reset tag read", v);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
